instruction_sequencer: RTL and testbench



---
 rtl/instruction_sequencer_if.sv | 27 ++
 rtl/instruction_sequencer.sv | 101 ++++++++++
 tb/tb_instruction_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - sequencer-to-memory/decoder bus with master/slave modports
interface instruction_sequencer_if #(
  parameter int OPCODE_WIDTH  = 3,
  parameter int OPERAND_WIDTH = 8,
  parameter int PC_WIDTH      = 5
);
  logic                                  start;
  logic                                  resume;
  logic [PC_WIDTH-1:0]                   imem_addr;
  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] imem_rdata;
  logic [OPCODE_WIDTH-1:0]               opcode;
  logic [OPERAND_WIDTH-1:0]              operand;
  logic                                  instr_valid;
  logic                                  f_wait;
  logic                                  busy;
  logic [PC_WIDTH-1:0]                   pc;

  modport master (
    input  start, resume, imem_rdata, f_wait,
    output imem_addr, opcode, operand, instr_valid, busy, pc
  );

  modport slave (
    output start, resume, imem_rdata, f_wait,
    input  imem_addr, opcode, operand, instr_valid, busy, pc
  );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - PC/IR sequencer feeding the decoder, FETCH/LOAD/EXEC slots with WAIT parking
// Define SEQ_LOOP_EN to wrap the program counter at PROG_LEN-1 instead of halting.
module instruction_sequencer #(
  parameter int                    OPCODE_WIDTH  = 3,
  parameter int                    OPERAND_WIDTH = 8,
  parameter int                    PC_WIDTH      = 5,
  parameter int                    PROG_LEN      = 32,
  parameter logic [OPCODE_WIDTH-1:0] NOP_OPCODE  = 3'b111
) (
  input logic                     clk,
  input logic                     rst,
  instruction_sequencer_if.master bus
);
  localparam int                  IW      = OPCODE_WIDTH + OPERAND_WIDTH;
  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_adv_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_adv_pc;
  logic [IW-1:0]       r_ir;
  logic [IW-1:0]       w_ir_nxt;
  logic                w_exec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // Where the program counter goes after an instruction retires.
  always_comb begin
    w_adv_state = S_FETCH;
    w_adv_pc    = r_pc + PC_WIDTH'(1);
    if (r_pc == LAST_PC) begin
`ifdef SEQ_LOOP_EN
      w_adv_pc    = '0;
      w_adv_state = S_FETCH;
`else
      w_adv_pc    = r_pc;
      w_adv_state = S_HALT;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_ir_nxt    = bus.imem_rdata;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (bus.f_wait) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = w_adv_state;
          w_pc_nxt    = w_adv_pc;
        end
      end
      S_WAIT: begin
        if (bus.resume) begin
          w_state_nxt = w_adv_state;
          w_pc_nxt    = w_adv_pc;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode only from registers, so f_wait cannot loop back through opcode.
  assign w_exec          = (r_state == S_EXEC);
  assign bus.opcode      = w_exec ? r_ir[IW-1 -: OPCODE_WIDTH] : NOP_OPCODE;
  assign bus.operand     = w_exec ? r_ir[OPERAND_WIDTH-1:0] : '0;
  assign bus.instr_valid = w_exec;
  assign bus.busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - vector table plus executed-instruction scoreboard for instruction_sequencer
module tb_instruction_sequencer;
  localparam int          OW      = 3;
  localparam int          DW      = 8;
  localparam int          PW      = 3;
  localparam int          PL      = 8;
  localparam logic [2:0]  NOP     = 3'b111;
  localparam logic [2:0]  WAIT_OP = 3'b110;

  typedef struct {
    logic       start;
    logic       resume;
    logic       valid;
    logic       busy;
    logic [2:0] op;
    logic [7:0] opd;
    logic [2:0] pc;
  } vec_t;

  typedef struct {
    logic [2:0] pc;
    logic [2:0] op;
    logic [7:0] opd;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [10:0] mem [PL];
  vec_t       tbl [14];
  sb_t        sb_q [$];
  logic       sb_en = 1'b0;
  int         n_checks = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  instruction_sequencer_if #(.OPCODE_WIDTH(OW), .OPERAND_WIDTH(DW), .PC_WIDTH(PW)) bus ();

  instruction_sequencer #(
    .OPCODE_WIDTH (OW),
    .OPERAND_WIDTH(DW),
    .PC_WIDTH     (PW),
    .PROG_LEN     (PL),
    .NOP_OPCODE   (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];
  assign bus.f_wait = (bus.opcode == WAIT_OP);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic v, input logic b,
                              input logic [2:0] op, input logic [7:0] opd, input logic [2:0] p);
    vec_t t;
    t.start = s; t.resume = r; t.valid = v; t.busy = b; t.op = op; t.opd = opd; t.pc = p;
    return t;
  endfunction

  always @(negedge clk) begin
    if (sb_en && bus.instr_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %0h expected no instruction", bus.pc);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_pc", 32'(bus.pc), 32'(e.pc));
        check("sb_opcode", 32'(bus.opcode), 32'(e.op));
        check("sb_operand", 32'(bus.operand), 32'(e.opd));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.resume = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  initial begin
    int  cyc;
    int  bad;
    int  xcnt;
    bit  done;
    bit  found;
    logic [2:0] wpc;

    mem[0] = {3'b001, 8'h11};
    mem[1] = {WAIT_OP, 8'h22};
    mem[2] = {3'b010, 8'h33};
    mem[3] = {3'b011, 8'h44};
    mem[4] = {3'b000, 8'h55};
    mem[5] = {3'b100, 8'h66};
    mem[6] = {3'b101, 8'h77};
    mem[7] = {3'b001, 8'h88};

    // Cycle-by-cycle trace from IDLE with stray start/resume pulses.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, NOP,    8'h00, 3'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, NOP,    8'h00, 3'd0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b1, NOP,    8'h00, 3'd0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 8'h11, 3'd0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, NOP,    8'h00, 3'd1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, NOP,    8'h00, 3'd1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, WAIT_OP, 8'h22, 3'd1);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, NOP,    8'h00, 3'd1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, NOP,    8'h00, 3'd1);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, NOP,    8'h00, 3'd1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, NOP,    8'h00, 3'd2);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, NOP,    8'h00, 3'd2);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 8'h33, 3'd2);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, NOP,    8'h00, 3'd3);

    bus.start = 1'b0;
    bus.resume = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'(NOP));
    check("rst_operand", 32'(bus.operand), 32'd0);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      bus.start = tbl[i].start;
      bus.resume = tbl[i].resume;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("v%0d_opcode", i), 32'(bus.opcode), 32'(tbl[i].op));
      check($sformatf("v%0d_operand", i), 32'(bus.operand), 32'(tbl[i].opd));
      check($sformatf("v%0d_pc", i), 32'(bus.pc), 32'(tbl[i].pc));
      check($sformatf("v%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].pc));
      @(posedge clk);
      #1;
    end

    // Full program through the scoreboard, holding WAIT for 10 cycles.
    do_reset();
    sb_q.delete();
    for (int i = 0; i < PL; i++) sb_q.push_back('{pc: 3'(i), op: mem[i][10:8], opd: mem[i][7:0]});
`ifdef SEQ_LOOP_EN
    sb_q.push_back('{pc: 3'd0, op: mem[0][10:8], opd: mem[0][7:0]});
`endif
    sb_en = 1'b1;
    pulse_start();
    cyc = 0;
    done = 1'b0;
    xcnt = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if ($isunknown(bus.imem_addr)) xcnt++;
      if (bus.instr_valid && bus.f_wait) begin
        wpc = bus.pc;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (bus.opcode !== NOP || bus.pc !== wpc || bus.instr_valid !== 1'b0) bad++;
        end
        check("wait_hold", 32'(bad), 32'd0);
        bus.resume = 1'b1;
        @(posedge clk);
        #1 bus.resume = 1'b0;
        @(negedge clk);
        check("resume_addr", 32'(bus.imem_addr), 32'(3'(wpc + 3'd1)));
      end
`ifdef SEQ_LOOP_EN
      done = (sb_q.size() == 0);
`else
      done = !bus.busy;
`endif
    end
    sb_en = 1'b0;
    check("sb_done", 32'(done), 32'd1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("addr_no_x", 32'(xcnt), 32'd0);
`ifdef SEQ_LOOP_EN
    @(negedge clk);
    check("wrap_fetch_pc", 32'(bus.pc), 32'd1);
`else
    check("halt_pc", 32'(bus.pc), 32'(PL - 1));
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.opcode !== NOP || bus.busy !== 1'b0 || bus.instr_valid !== 1'b0) bad++;
    end
    check("halt_hold", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    pulse_start();
    repeat (2) @(negedge clk);
    check("halt_ignores_start", 32'(bus.busy), 32'd0);
`endif

    // Asynchronous reset landing in EXEC of pc 5.
    do_reset();
    pulse_start();
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.instr_valid && bus.pc == 3'd5) begin
        found = 1'b1;
      end else if (bus.instr_valid && bus.f_wait) begin
        @(posedge clk);
        #1 bus.resume = 1'b1;
        @(posedge clk);
        #1 bus.resume = 1'b0;
      end
    end
    check("arst_reach_exec", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_opcode", 32'(bus.opcode), 32'(NOP));
    check("arst_pc", 32'(bus.pc), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("arst_idle_busy", 32'(bus.busy), 32'd0);
    check("arst_idle_pc", 32'(bus.pc), 32'd0);
    @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    check("arst_restart_busy", 32'(bus.busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
